// File: rtl/bicubic_phase_sched.sv
// ---------------------------------------------------------------------------
// bicubic_phase_sched
//
// Row-phase scheduler for the bicubic vertical weight datapath. For each frame
// a DDA accumulator walks the destination rows. One fractional phase (yBlend,
// Q1.8) and the latched bicubic "a" coefficient are issued per row into a
// fixed-latency weight pipeline. The returned weights and their source row
// index are collected into a small output FIFO, which downstream drains with
// a valid/ready handshake. Issue is credit-limited, so the FIFO cannot
// overflow.
//
// Optional build macro: BICUBIC_CENTER_ALIGN_EN
//   defined   : half-pixel centre alignment, initial acc = (step>>1) - 0.5,
//               clamped at 0
//   undefined : corner alignment, initial acc = 0
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   start               one-cycle pulse that begins a frame (ignored when busy)
//   src_rows, dst_rows  source and destination row counts
//   step                src/dst ratio, unsigned Q(SIZE_W).FRAC_W
//   coeff_a             bicubic a, Q1.8
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   phase_out, a_out    request payload to the weight datapath
//   phase_vld           request strobe to the weight datapath
//   wt_in               weight returned PIPE_LAT cycles after phase_vld
//   wt_vld, wt_idx,     registered FIFO head (source row index and weight)
//   wt_data
//   wt_rdy              downstream ready; pop on wt_vld && wt_rdy
// ---------------------------------------------------------------------------
module bicubic_phase_sched #(
  parameter int PIPE_LAT   = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int SIZE_W     = 12,
  parameter int FRAC_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SIZE_W-1:0]        src_rows,
  input  logic [SIZE_W-1:0]        dst_rows,
  input  logic [SIZE_W+FRAC_W-1:0] step,
  input  logic [8:0]               coeff_a,
  output logic                     busy,
  output logic                     done,
  output logic [FRAC_W:0]          phase_out,
  output logic [8:0]               a_out,
  output logic                     phase_vld,
  input  logic [8:0]               wt_in,
  output logic                     wt_vld,
  output logic [SIZE_W-1:0]        wt_idx,
  output logic [8:0]               wt_data,
  input  logic                     wt_rdy
);

  localparam int ACC_W = SIZE_W + FRAC_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = SIZE_W + 9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  // Integer row of the accumulator, clamped to the last source row.
  function automatic logic [SIZE_W-1:0] clamp_idx(input logic [ACC_W-1:0]  acc,
                                                  input logic [SIZE_W-1:0] rows);
    logic [SIZE_W-1:0] whole;
    logic [SIZE_W-1:0] last;
    whole = acc[ACC_W-1:FRAC_W];
    last  = rows - SIZE_W'(1);
    return (whole > last) ? last : whole;
  endfunction

`ifdef BICUBIC_CENTER_ALIGN_EN
  localparam logic [ACC_W-1:0] HALF_PIX = ACC_W'(1 << (FRAC_W - 1));

  // Half-pixel offset of the first destination row, clamped at zero.
  function automatic logic [ACC_W-1:0] center_acc(input logic [ACC_W-1:0] stp);
    logic [ACC_W-1:0] half;
    half = stp >> 1;
    return (half < HALF_PIX) ? '0 : (half - HALF_PIX);
  endfunction
`endif

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 phase_vld_q, phase_vld_d;
  logic [FRAC_W:0]      phase_out_q, phase_out_d;
  logic [8:0]           a_out_q, a_out_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     step_q, step_d;
  logic [SIZE_W-1:0]    src_q, src_d;
  logic [SIZE_W-1:0]    dst_q, dst_d;
  logic [SIZE_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [SIZE_W-1:0]    idx_q, idx_d;
  logic [PIPE_LAT-1:0]  sr_vld_q, sr_vld_d;
  logic [SIZE_W-1:0]    sr_idx_q [PIPE_LAT];
  logic [SIZE_W-1:0]    sr_idx_d [PIPE_LAT];
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic                 pop;
  logic                 exit_vld;
  logic                 issue;
  logic                 start_ok;
  logic                 credit_ok;
  logic [CNT_W:0]       outstanding;
  logic [ACC_W-1:0]     acc_start;

  assign pop      = (fifo_cnt_q != '0) && wt_rdy;
  assign exit_vld = sr_vld_q[PIPE_LAT-1];
  // The done cycle is treated as part of the frame, so a start there is dropped.
  assign start_ok = (state_q == S_IDLE) && !done_q && start;

  // Credit: every request from issue until it leaves the FIFO. A pop in this
  // same cycle frees its slot, which sustains one row per cycle with ready high.
  assign outstanding = {1'b0, inflight_q} + {1'b0, fifo_cnt_q} - (CNT_W+1)'(pop);
  assign credit_ok   = outstanding < (CNT_W+1)'(FIFO_DEPTH);

`ifdef BICUBIC_CENTER_ALIGN_EN
  assign acc_start = center_acc(step);
`else
  assign acc_start = '0;
`endif

  // Stage: frame control and DDA issue
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    phase_vld_d = 1'b0;
    phase_out_d = phase_out_q;
    a_out_d     = a_out_q;
    acc_d       = acc_q;
    step_d      = step_q;
    src_d       = src_q;
    dst_d       = dst_q;
    issue_cnt_d = issue_cnt_q;
    idx_d       = idx_q;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          src_d       = src_rows;
          dst_d       = dst_rows;
          step_d      = step;
          a_out_d     = coeff_a;
          acc_d       = acc_start;
          issue_cnt_d = '0;
          busy_d      = 1'b1;
          state_d     = (dst_rows == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue       = 1'b1;
          phase_vld_d = 1'b1;
          phase_out_d = {1'b0, acc_q[FRAC_W-1:0]};
          idx_d       = clamp_idx(acc_q, src_q);
          acc_d       = acc_q + step_q;
          issue_cnt_d = issue_cnt_q + SIZE_W'(1);
          if (issue_cnt_d == dst_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && (fifo_cnt_q == '0)) state_d = S_FIN;
      end
      default: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage: in-flight tracking, aligned so the exit stage meets wt_in
  always_comb begin
    sr_vld_d    = {sr_vld_q[PIPE_LAT-2:0], phase_vld_q};
    sr_idx_d[0] = idx_q;
    for (int i = 1; i < PIPE_LAT; i++) sr_idx_d[i] = sr_idx_q[i-1];
    inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(exit_vld);
  end

  // Stage: output FIFO
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(exit_vld) - CNT_W'(pop);
    if (exit_vld) begin
      mem_d[wr_ptr_q] = {sr_idx_q[PIPE_LAT-1], wt_in};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_vld_q <= 1'b0;
      phase_out_q <= '0;
      a_out_q     <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      issue_cnt_q <= '0;
      idx_q       <= '0;
      sr_vld_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) sr_idx_q[i] <= '0;
      inflight_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      phase_vld_q <= phase_vld_d;
      phase_out_q <= phase_out_d;
      a_out_q     <= a_out_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      issue_cnt_q <= issue_cnt_d;
      idx_q       <= idx_d;
      sr_vld_q    <= sr_vld_d;
      sr_idx_q    <= sr_idx_d;
      inflight_q  <= inflight_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign phase_vld         = phase_vld_q;
  assign phase_out         = phase_out_q;
  assign a_out             = a_out_q;
  assign wt_vld            = (fifo_cnt_q != '0);
  assign {wt_idx, wt_data} = mem_q[rd_ptr_q];

endmodule
